axis_packet_buffer: RTL and testbench

//  Store-and-forward AXI-Stream packet FIFO placed directly downstream of data_width_converter.
//  - Accepts beats (data/keep/last) at the converter's output width.
//  - Releases a packet downstream only after its TLAST beat has been written, so the consumer

---
 rtl/axis_packet_buffer_pkg.sv | 26 ++
 rtl/axis_packet_buffer_sdp_ram.sv | 31 +++
 rtl/axis_packet_buffer.sv | 151 +++++++++++++++
 tb/tb_axis_packet_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_buffer_pkg.sv
// Shared definitions for the AXI-Stream store-and-forward packet buffer:
// keep-width derivation, a ceil-log2 helper and the commit-mode encoding.
package axis_packet_buffer_pkg;

  localparam int BYTE_W = 8;

  function automatic int keep_width(input int data_width);
    return data_width / BYTE_W;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Cut-through is entered only when one partial packet fills the buffer.
  typedef enum logic [0:0] {
    MODE_STORE_FWD   = 1'b0,
    MODE_CUT_THROUGH = 1'b1
  } commit_mode_e;

endpackage

// File: rtl/axis_packet_buffer_sdp_ram.sv
// Simple dual-port entry store: one write port, one registered read port.
// The array itself is never reset.
module axis_packet_buffer_sdp_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axis_packet_buffer.sv
// Store-and-forward AXI-Stream packet FIFO with cut-through fallback for oversize packets.
// Optional status outputs (o_free_words, o_packet_count) when AXIS_PKT_BUF_STATUS_EN is defined.
module axis_packet_buffer
  import axis_packet_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = 512,
  parameter  int DEPTH      = 64,
  localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
  localparam int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_input_valid,
  output logic                  o_input_ready,
  input  logic [DATA_WIDTH-1:0] i_input_data,
  input  logic [KEEP_WIDTH-1:0] i_input_keep,
  input  logic                  i_input_last,
  output logic                  o_output_valid,
  input  logic                  i_output_ready,
  output logic [DATA_WIDTH-1:0] o_output_data,
  output logic [KEEP_WIDTH-1:0] o_output_keep,
  output logic                  o_output_last,
`ifdef AXIS_PKT_BUF_STATUS_EN
  output logic [ADDR_W:0]       o_free_words,
  output logic [ADDR_W:0]       o_packet_count,
`endif
  output logic                  o_oversize
);

  localparam int              ENTRY_W    = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH - 1);

  logic [ADDR_W:0]       r_wr_ptr, r_commit_ptr, r_rd_ptr, r_fetch_ptr;
  logic                  r_in_ready, r_ram_valid, r_out_valid, r_out_last, r_oversize;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [KEEP_WIDTH-1:0] r_out_keep;
  commit_mode_e          r_mode;

  logic                  w_wr_en, w_drain, w_load_out, w_fetch;
  logic                  w_full, w_overflow, w_commit_beat;
  logic [ADDR_W:0]       w_used, w_used_next, w_wr_ptr_next, w_rd_ptr_next;
  logic [ENTRY_W-1:0]    w_rd_entry;

  // rd_ptr retires beats on the output handshake; fetch_ptr runs ahead into the read pipeline.
  assign w_wr_en       = i_input_valid && r_in_ready;
  assign w_drain       = r_out_valid && i_output_ready;
  assign w_load_out    = r_ram_valid && (!r_out_valid || w_drain);
  assign w_fetch       = (r_fetch_ptr != r_commit_ptr) && (!r_ram_valid || w_load_out);
  assign w_used        = r_wr_ptr - r_rd_ptr;
  assign w_full        = w_used >= FULL_LEVEL;
  assign w_overflow    = w_full && (r_commit_ptr == r_rd_ptr);
  assign w_commit_beat = w_wr_en && (i_input_last || (r_mode == MODE_CUT_THROUGH));
  assign w_wr_ptr_next = w_wr_en ? r_wr_ptr + PTR_ONE : r_wr_ptr;
  assign w_rd_ptr_next = w_drain ? r_rd_ptr + PTR_ONE : r_rd_ptr;
  assign w_used_next   = w_wr_ptr_next - w_rd_ptr_next;

  axis_packet_buffer_sdp_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data ({i_input_last, i_input_keep, i_input_data}),
    .i_rd_en   (w_fetch),
    .i_rd_addr (r_fetch_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_entry)
  );

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_fetch_ptr  <= '0;
      r_in_ready   <= 1'b0;
      r_mode       <= MODE_STORE_FWD;
      r_oversize   <= 1'b0;
      r_ram_valid  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_in_ready <= w_used_next < FULL_LEVEL;
      // Overflow can only fire while input is stalled, so it never races a commit.
      if (w_commit_beat) begin
        r_commit_ptr <= r_wr_ptr + PTR_ONE;
      end else if (w_overflow) begin
        r_commit_ptr <= r_wr_ptr;
      end
      if (w_overflow) begin
        r_mode     <= MODE_CUT_THROUGH;
        r_oversize <= 1'b1;
      end else if (w_wr_en && i_input_last) begin
        r_mode <= MODE_STORE_FWD;
      end
      if (w_fetch) begin
        r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
      end
      if (w_fetch) begin
        r_ram_valid <= 1'b1;
      end else if (w_load_out) begin
        r_ram_valid <= 1'b0;
      end
      if (w_load_out) begin
        r_out_valid <= 1'b1;
        {r_out_last, r_out_keep, r_out_data} <= w_rd_entry;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_PKT_BUF_STATUS_EN
  logic [ADDR_W:0] r_free_words, r_packet_count;
  logic            w_pkt_inc, w_pkt_dec;

  assign w_pkt_inc = w_wr_en && i_input_last;
  assign w_pkt_dec = w_drain && r_out_last;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_free_words   <= '0;
      r_packet_count <= '0;
    end else begin
      r_free_words <= (ADDR_W+1)'(DEPTH) - w_used_next;
      if (w_pkt_inc && !w_pkt_dec) begin
        r_packet_count <= r_packet_count + PTR_ONE;
      end else if (w_pkt_dec && !w_pkt_inc) begin
        r_packet_count <= r_packet_count - PTR_ONE;
      end
    end
  end

  assign o_free_words   = r_free_words;
  assign o_packet_count = r_packet_count;
`endif

  assign o_input_ready  = r_in_ready;
  assign o_output_valid = r_out_valid;
  assign o_output_data  = r_out_data;
  assign o_output_keep  = r_out_keep;
  assign o_output_last  = r_out_last;
  assign o_oversize     = r_oversize;

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Randomized self-checking bench for axis_packet_buffer (DEPTH=8, 32-bit data) against a
// queue-based packet model; also exercises AXIS_PKT_BUF_STATUS_EN outputs when defined.
module tb_axis_packet_buffer;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BW    = DW + KW + 1;

  logic          i_clk;
  logic          i_aresetn;
  logic          i_input_valid;
  logic          o_input_ready;
  logic [DW-1:0] i_input_data;
  logic [KW-1:0] i_input_keep;
  logic          i_input_last;
  logic          o_output_valid;
  logic          i_output_ready;
  logic [DW-1:0] o_output_data;
  logic [KW-1:0] o_output_keep;
  logic          o_output_last;
  logic          o_oversize;
`ifdef AXIS_PKT_BUF_STATUS_EN
  logic [AW:0]   o_free_words;
  logic [AW:0]   o_packet_count;
`endif

  axis_packet_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .i_aresetn      (i_aresetn),
    .i_input_valid  (i_input_valid),
    .o_input_ready  (o_input_ready),
    .i_input_data   (i_input_data),
    .i_input_keep   (i_input_keep),
    .i_input_last   (i_input_last),
    .o_output_valid (o_output_valid),
    .i_output_ready (i_output_ready),
    .o_output_data  (o_output_data),
    .o_output_keep  (o_output_keep),
    .o_output_last  (o_output_last),
`ifdef AXIS_PKT_BUF_STATUS_EN
    .o_free_words   (o_free_words),
    .o_packet_count (o_packet_count),
`endif
    .o_oversize     (o_oversize)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: beats are {last, keep, data}; the buffer must return them in order.
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] tx_q[$];
  logic [BW-1:0] cur_beat;
  bit            cur_valid;
  int acc_cnt, cons_cnt, commit_beats, pkts_in, pkts_out, out_beats;
  int cyc, tlast_cyc, first_out_cyc, last_out_cyc;
  int in_rate = 100;
  bit allow_ct, lat_armed;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    tx_q.delete();
    cur_valid    = 1'b0;
    acc_cnt      = 0;
    cons_cnt     = 0;
    commit_beats = 0;
    pkts_in      = 0;
    pkts_out     = 0;
    out_beats    = 0;
    allow_ct     = 1'b0;
    lat_armed    = 1'b0;
  endtask

  task automatic queue_packet(input int len);
    logic [BW-1:0] beat;
    for (int i = 0; i < len; i++) begin
      beat = {(i == len - 1), 4'($urandom_range(1, 15)), 32'($urandom)};
      tx_q.push_back(beat);
    end
  endtask

  task automatic apply_reset();
    i_aresetn      = 1'b0;
    i_input_valid  = 1'b0;
    i_input_data   = '0;
    i_input_keep   = '0;
    i_input_last   = 1'b0;
    i_output_ready = 1'b0;
    #1;
    check_value("rst_in_ready", o_input_ready, 0);
    check_value("rst_out_valid", o_output_valid, 0);
    check_value("rst_out_beat", {o_output_last, o_output_keep, o_output_data}, 0);
    check_value("rst_oversize", o_oversize, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_aresetn = 1'b1;
    model_clear();
    @(posedge i_clk);
    #1;
    cyc++;
    check_value("rst_ready_rise", o_input_ready, 1);
  endtask

  // One clock: drive, record handshakes before the edge, then update model and check.
  task automatic step(input bit out_ready);
    bit            fire_in, fire_out, stalled;
    logic [BW-1:0] held, exp;
    if (!cur_valid && tx_q.size() > 0 && $urandom_range(0, 99) < in_rate) begin
      cur_beat  = tx_q.pop_front();
      cur_valid = 1'b1;
    end
    i_input_valid = cur_valid;
    {i_input_last, i_input_keep, i_input_data} = cur_valid ? cur_beat : '0;
    i_output_ready = out_ready;
    fire_in  = cur_valid && o_input_ready;
    fire_out = o_output_valid && out_ready;
    stalled  = o_output_valid && !out_ready;
    held     = {o_output_last, o_output_keep, o_output_data};
    @(posedge i_clk);
    #1;
    cyc++;
    if (fire_in) begin
      exp_q.push_back(cur_beat);
      acc_cnt++;
      if (cur_beat[BW-1]) begin
        commit_beats = acc_cnt;
        pkts_in++;
        tlast_cyc = cyc;
      end
      cur_valid = 1'b0;
    end
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        check_value("out_unexpected", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_value("out_beat", held, exp);
      end
      if (!allow_ct) check_value("store_fwd", cons_cnt < commit_beats, 1);
      cons_cnt++;
      if (held[BW-1]) pkts_out++;
      if (out_beats == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_beats++;
    end
    if (stalled) check_value("hold", {o_output_valid, o_output_last, o_output_keep, o_output_data}, {1'b1, held});
    check_value("in_ready", o_input_ready, (acc_cnt - cons_cnt) < DEPTH - 1);
`ifdef AXIS_PKT_BUF_STATUS_EN
    check_value("free_words", o_free_words, DEPTH - (acc_cnt - cons_cnt));
    check_value("packet_count", o_packet_count, pkts_in - pkts_out);
`endif
    if (lat_armed && o_output_valid) begin
      check_value("latency", cyc - tlast_cyc, 2);
      lat_armed = 1'b0;
    end
  endtask

  task automatic run_until_idle(input int budget, input int ready_pct);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || cur_valid || exp_q.size() > 0) && n < budget) begin
      step($urandom_range(0, 99) < ready_pct);
      n++;
    end
    check_value("drain_done", tx_q.size() + exp_q.size() + int'(cur_valid), 0);
  endtask

  initial begin
    bit pat[4];
    int n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0;
    tlast_cyc = 0;
    first_out_cyc = 0;
    last_out_cyc = 0;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    apply_reset();

    // 1: single 4-beat packet, sink always ready
    in_rate = 100;
    lat_armed = 1'b1;
    queue_packet(4);
    run_until_idle(50, 100);
    check_value("s1_beats", out_beats, 4);

    // 2: backpressure pattern 1,0,0,1 on a 3-beat packet
    queue_packet(3);
    n = 0;
    while ((tx_q.size() > 0 || cur_valid || exp_q.size() > 0) && n < 100) begin
      step(pat[n % 4]);
      n++;
    end
    check_value("s2_done", exp_q.size(), 0);
    check_value("s2_pkts", pkts_out, 2);

    // 3: fill with seven 1-beat packets while the sink is stalled, then drain
    for (int i = 0; i < 7; i++) queue_packet(1);
    n = 0;
    while ((tx_q.size() > 0 || cur_valid) && n < 30) begin
      step(1'b0);
      n++;
    end
    step(1'b0);
    check_value("s3_full_ready", o_input_ready, 0);
    check_value("s3_out_valid", o_output_valid, 1);
    run_until_idle(100, 100);
    check_value("s3_pkts", pkts_out, 2 + 7);
    check_value("s3_ready_back", o_input_ready, 1);

    // 4: 12-beat packet overflows into cut-through, then a normal 2-beat packet
    apply_reset();
    allow_ct = 1'b1;
    queue_packet(12);
    run_until_idle(300, 100);
    check_value("s4_oversize", o_oversize, 1);
    check_value("s4_beats", out_beats, 12);
    allow_ct  = 1'b0;
    lat_armed = 1'b1;
    queue_packet(2);
    run_until_idle(100, 100);
    check_value("s4_pkts", pkts_out, 2);
    check_value("s4_sticky", o_oversize, 1);

    // 5: reset after 3 of 5 beats, then a fresh 2-beat packet
    apply_reset();
    queue_packet(5);
    n = 0;
    while (acc_cnt < 3 && n < 30) begin
      step(1'b1);
      n++;
    end
    check_value("s5_partial", acc_cnt, 3);
    apply_reset();
    lat_armed = 1'b1;
    queue_packet(2);
    run_until_idle(100, 100);
    check_value("s5_beats", out_beats, 2);
    check_value("s5_pkts", pkts_out, 1);

    // 6: back-to-back 1-beat packets at full rate
    apply_reset();
    for (int i = 0; i < 16; i++) queue_packet(1);
    run_until_idle(100, 100);
    check_value("s6_beats", out_beats, 16);
    check_value("s6_throughput", last_out_cyc - first_out_cyc, 15);
`ifdef AXIS_PKT_BUF_STATUS_EN
    check_value("s6_pkt_count_idle", o_packet_count, 0);
`endif

    // 7: random packets with random source and sink gaps
    in_rate = 70;
    for (int i = 0; i < 40; i++) queue_packet($urandom_range(1, 5));
    run_until_idle(5000, 60);
    check_value("s7_pkts", pkts_out, 16 + 40);
    check_value("s7_no_oversize", o_oversize, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
